// File: rtl/ulpi_pkg.sv
// ulpi_pkg: constants and state encoding shared by the ULPI link-side logic.
//   TXCMD_*  : two-bit command prefixes placed in DATA[7:6] of a TX CMD byte
//   END_*    : byte driven alongside STP; 0xFF forces a bit-stuff error so
//              the PHY aborts the packet on the wire
//   state_t  : transmit-side state encoding
package ulpi_pkg;

    localparam logic [1:0] TXCMD_TRANSMIT = 2'b01;
    localparam logic [1:0] TXCMD_REGWR    = 2'b10;

    localparam logic [7:0] END_OK    = 8'h00;
    localparam logic [7:0] END_ABORT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TXCMD,
        S_DATA,
        S_STOP,
        S_REG_CMD,
        S_REG_DATA,
        S_FLUSH,
        S_GAP
    } state_t;

endpackage

// File: rtl/ulpi_send.sv
// ulpi_send: link-to-PHY transmit side of a ULPI bus (USB3300 class PHY).
// Sends USB packets (TX CMD carrying the PID, data bytes, STP) and PHY
// register writes (register-write TX CMD, value, STP) and yields the bus to
// the PHY whenever DIR is high. All flops use the falling edge of clk_ULPI,
// matching the receive path.
//
// Ports:
//   clk_ULPI     60 MHz ULPI clock (falling-edge logic)
//   rst          asynchronous active-high reset
//   tx_valid/tx_data/tx_last/tx_ready
//                first-word-fall-through byte source; first byte is the PID;
//                tx_ready marks the byte consumed this cycle
//   reg_wr_req/reg_addr/reg_wr_data/reg_wr_done
//                PHY register write; request held until the done pulse
//   tx_done      pulse: packet ended normally
//   tx_abort     pulse: packet aborted by the PHY (DIR) or by source underrun
//   tx_count     bytes sent in the last packet, PID included
//   busy         transmitter not idle
//   DIR/NXT      ULPI direction / next from the PHY
//   DATA_O/DATA_OE/STP
//                ULPI data toward the PHY, its output enable, and stop
module ulpi_send #(
    parameter int CNT_W      = 10,
    parameter int IFG_CYCLES = 2
) (
    input  logic             clk_ULPI,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    input  logic             tx_last,
    output logic             tx_ready,
    input  logic             reg_wr_req,
    input  logic [5:0]       reg_addr,
    input  logic [7:0]       reg_wr_data,
    output logic             reg_wr_done,
    output logic             tx_done,
    output logic             tx_abort,
    output logic [CNT_W-1:0] tx_count,
    output logic             busy,
    input  logic             DIR,
    input  logic             NXT,
    output logic [7:0]       DATA_O,
    output logic             DATA_OE,
    output logic             STP
);

    import ulpi_pkg::*;

    // GAP lasts max(IFG_CYCLES,1) cycles; the counter only needs to reach
    // the last of them.
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        (IFG_CYCLES > 1) ? GAP_W'(IFG_CYCLES - 1) : '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state_q, state_d;
    logic               dir_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         end_q, end_d;
    logic               is_reg_q, is_reg_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               tx_done_q, tx_done_d;
    logic               tx_abort_q, tx_abort_d;
    logic               reg_wr_done_q, reg_wr_done_d;
    logic [CNT_W-1:0]   tx_count_q, tx_count_d;
    logic               tx_ready_c;
    logic [7:0]         data_mux;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        end_d         = end_q;
        is_reg_d      = is_reg_q;
        gap_d         = gap_q;
        tx_done_d     = 1'b0;
        tx_abort_d    = 1'b0;
        reg_wr_done_d = 1'b0;
        tx_count_d    = tx_count_q;
        tx_ready_c    = 1'b0;
        data_mux      = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                // dir_q guarantees one turnaround cycle after DIR falls.
                if (!DIR && !dir_q) begin
                    if (reg_wr_req) begin
                        state_d  = S_REG_CMD;
                        is_reg_d = 1'b1;
                    end else if (tx_valid) begin
                        state_d  = S_TXCMD;
                        is_reg_d = 1'b0;
                    end
                end
            end
            S_TXCMD: begin
                data_mux = {TXCMD_TRANSMIT, 2'b00, tx_data[3:0]};
                if (DIR) begin
                    // PID left at the source; IDLE retries it.
                    state_d = S_IDLE;
                end else if (NXT) begin
                    tx_ready_c = 1'b1;
                    count_d    = CNT_W'(1);
                    if (tx_last) begin
                        state_d = S_STOP;
                        end_d   = END_OK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                data_mux   = tx_data;
                tx_ready_c = NXT && tx_valid && !DIR;
                if (DIR) begin
                    tx_abort_d = 1'b1;
                    tx_count_d = count_q;
                    state_d    = S_FLUSH;
                end else if (NXT) begin
                    if (tx_valid) begin
                        count_d = sat_inc(count_q);
                        if (tx_last) begin
                            state_d = S_STOP;
                            end_d   = END_OK;
                        end
                    end else begin
                        // Underrun: PHY wants a byte we do not have.
                        state_d = S_STOP;
                        end_d   = END_ABORT;
                    end
                end
            end
            S_STOP: begin
                data_mux = end_q;
                state_d  = S_GAP;
                gap_d    = '0;
                if (is_reg_q) begin
                    reg_wr_done_d = 1'b1;
                end else if (end_q == END_ABORT) begin
                    tx_abort_d = 1'b1;
                    tx_count_d = count_q;
                end else begin
                    tx_done_d  = 1'b1;
                    tx_count_d = count_q;
                end
            end
            S_REG_CMD: begin
                data_mux = {TXCMD_REGWR, reg_addr};
                if (DIR) begin
                    state_d = S_IDLE;
                end else if (NXT) begin
                    state_d = S_REG_DATA;
                end
            end
            S_REG_DATA: begin
                data_mux = reg_wr_data;
                if (DIR) begin
                    state_d = S_IDLE;
                end else if (NXT) begin
                    state_d = S_STOP;
                    end_d   = END_OK;
                end
            end
            S_FLUSH: begin
                // Drain the rest of the aborted packet from the source.
                tx_ready_c = tx_valid;
                if (tx_valid && tx_last) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clk_ULPI or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dir_q         <= 1'b0;
            count_q       <= '0;
            end_q         <= END_OK;
            is_reg_q      <= 1'b0;
            gap_q         <= '0;
            tx_done_q     <= 1'b0;
            tx_abort_q    <= 1'b0;
            reg_wr_done_q <= 1'b0;
            tx_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= DIR;
            count_q       <= count_d;
            end_q         <= end_d;
            is_reg_q      <= is_reg_d;
            gap_q         <= gap_d;
            tx_done_q     <= tx_done_d;
            tx_abort_q    <= tx_abort_d;
            reg_wr_done_q <= reg_wr_done_d;
            tx_count_q    <= tx_count_d;
        end
    end

    // The link drives the bus only in the active transmit states and never
    // while the PHY owns it.
    assign DATA_OE = !DIR && (state_q inside {S_TXCMD, S_DATA, S_STOP,
                                              S_REG_CMD, S_REG_DATA});
    assign DATA_O      = DATA_OE ? data_mux : 8'h00;
    assign STP         = (state_q == S_STOP);
    assign busy        = (state_q != S_IDLE);
    assign tx_ready    = tx_ready_c;
    assign tx_done     = tx_done_q;
    assign tx_abort    = tx_abort_q;
    assign reg_wr_done = reg_wr_done_q;
    assign tx_count    = tx_count_q;

endmodule

// File: tb/tb_ulpi_send.sv
// tb_ulpi_send: directed bench for ulpi_send. A FWFT byte source, a simple
// PHY NXT responder and a scripted DIR driver stimulate the DUT; observed
// bus bytes and pulses are logged and compared with hand-computed values.
module tb_ulpi_send;

    localparam int CNT_W = 10;

    logic             clk_ULPI = 1'b0;
    logic             rst = 1'b1;
    logic             tx_valid = 1'b0;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_last = 1'b0;
    logic             tx_ready;
    logic             reg_wr_req = 1'b0;
    logic [5:0]       reg_addr = 6'h00;
    logic [7:0]       reg_wr_data = 8'h00;
    logic             reg_wr_done;
    logic             tx_done;
    logic             tx_abort;
    logic [CNT_W-1:0] tx_count;
    logic             busy;
    logic             DIR = 1'b0;
    logic             NXT = 1'b0;
    logic [7:0]       DATA_O;
    logic             DATA_OE;
    logic             STP;

    ulpi_send #(.CNT_W(CNT_W), .IFG_CYCLES(2)) dut (
        .clk_ULPI   (clk_ULPI),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .reg_wr_req (reg_wr_req),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_wr_done(reg_wr_done),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .tx_count   (tx_count),
        .busy       (busy),
        .DIR        (DIR),
        .NXT        (NXT),
        .DATA_O     (DATA_O),
        .DATA_OE    (DATA_OE),
        .STP        (STP)
    );

    always #5 clk_ULPI = ~clk_ULPI;

    int n_checks = 0;
    int n_errors = 0;

    // source / PHY / DIR script state
    logic [8:0] src_q[$];
    int  popped;
    bit  rdy_seen;
    bit  drop_req;
    int  nxt_delay;
    bit  nxt_per_byte;
    int  wait_cnt;
    int  dir_trig_pops;
    bit  dir_trig_busy;
    int  dir_len;
    int  dir_left;
    // logs
    logic [7:0] nxt_log[$];
    logic [7:0] stp_log[$];
    logic [7:0] oe_log[$];
    int  n_ready, n_done, n_abort, n_regdone;
    int  cnt_at_end, cyc, done_cyc, regdone_cyc;
    int  last_stp_cyc, gap_meas, viol, dir_busy;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        nxt_log.delete(); stp_log.delete(); oe_log.delete();
        n_ready = 0; n_done = 0; n_abort = 0; n_regdone = 0;
        cnt_at_end = -1; done_cyc = -1; regdone_cyc = -1;
        last_stp_cyc = -1; gap_meas = -1; viol = 0; dir_busy = 0;
        popped = 0; wait_cnt = 0; dir_trig_pops = -1; dir_trig_busy = 0;
        dir_left = 0;
    endtask

    task automatic push_pkt(input logic [7:0] b, input bit last);
        src_q.push_back({last, b});
    endtask

    task automatic tick();
        @(posedge clk_ULPI); #1;
        cyc++;
        if (rdy_seen && src_q.size() > 0) begin
            void'(src_q.pop_front());
            popped++;
        end
        rdy_seen = 1'b0;
        if (src_q.size() > 0) begin
            tx_valid = 1'b1; tx_data = src_q[0][7:0]; tx_last = src_q[0][8];
        end else begin
            tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        end
        if (drop_req) begin
            reg_wr_req = 1'b0;
            drop_req = 1'b0;
        end
        if (dir_trig_pops >= 0 && popped == dir_trig_pops) begin
            dir_left = dir_len; dir_trig_pops = -1;
        end
        if (dir_trig_busy && busy) begin
            dir_left = dir_len; dir_trig_busy = 0;
        end
        DIR = (dir_left > 0);
        if (dir_left > 0) dir_left--;
        #1;
        if (DATA_OE && !STP) begin
            if (wait_cnt >= nxt_delay) begin
                NXT = 1'b1;
                if (nxt_per_byte) wait_cnt = 0;
            end else begin
                NXT = 1'b0;
                wait_cnt++;
            end
        end else begin
            NXT = 1'b0;
            wait_cnt = 0;
        end
        #2;
        if (DATA_OE) oe_log.push_back(DATA_O);
        if (DATA_OE && NXT && !STP) nxt_log.push_back(DATA_O);
        if (STP) begin
            stp_log.push_back(DATA_O);
            last_stp_cyc = cyc;
        end else if (DATA_OE && last_stp_cyc >= 0 && gap_meas < 0) begin
            gap_meas = cyc - last_stp_cyc - 1;
        end
        if (tx_ready) n_ready++;
        rdy_seen = tx_ready;
        if (tx_done) begin n_done++; cnt_at_end = int'(tx_count); done_cyc = cyc; end
        if (tx_abort) begin n_abort++; cnt_at_end = int'(tx_count); end
        if (reg_wr_done) begin n_regdone++; regdone_cyc = cyc; drop_req = 1'b1; end
        if (!DATA_OE && DATA_O != 8'h00) viol++;
        if (DIR && DATA_OE) viol++;
        if (DIR && busy) dir_busy++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int cnt_val(input logic [7:0] v);
        int c = 0;
        foreach (oe_log[i]) if (oe_log[i] == v) c++;
        return c;
    endfunction

    function automatic int log_at(input int idx);
        return (idx < nxt_log.size()) ? int'(nxt_log[idx]) : -1;
    endfunction

    initial begin
        cyc = 0; rdy_seen = 0; drop_req = 0;
        nxt_delay = 1; nxt_per_byte = 0; dir_len = 2;
        clear_logs();

        // reset state, with live-looking inputs applied
        repeat (3) @(posedge clk_ULPI);
        #1;
        tx_valid = 1'b1; tx_data = 8'hC3; NXT = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_oe", DATA_OE, 0);
        chk("rst_data", DATA_O, 0);
        chk("rst_stp", STP, 0);
        chk("rst_ready", tx_ready, 0);
        chk("rst_count", int'(tx_count), 0);
        tx_valid = 1'b0; tx_data = 8'h00; NXT = 1'b0;
        @(posedge clk_ULPI); #1;
        rst = 1'b0;
        run(3);

        // T1: C3, 11, 22(last), NXT held after one cycle
        clear_logs(); nxt_delay = 1; nxt_per_byte = 0;
        push_pkt(8'hC3, 0); push_pkt(8'h11, 0); push_pkt(8'h22, 1);
        run(20);
        chk("t1_b0", log_at(0), 8'h43);
        chk("t1_b1", log_at(1), 8'h11);
        chk("t1_b2", log_at(2), 8'h22);
        chk("t1_nbytes", nxt_log.size(), 3);
        chk("t1_stp", stp_log.size() > 0 ? int'(stp_log[0]) : -1, 8'h00);
        chk("t1_done", n_done, 1);
        chk("t1_abort", n_abort, 0);
        chk("t1_count", cnt_at_end, 3);
        chk("t1_ready", n_ready, 3);
        chk("t1_viol", viol, 0);

        // T2: register write 0x0A <= 0x45, NXT after two idle cycles per byte
        clear_logs(); nxt_delay = 2; nxt_per_byte = 1;
        reg_addr = 6'h0A; reg_wr_data = 8'h45; reg_wr_req = 1'b1;
        run(20);
        chk("t2_b0", log_at(0), 8'h8A);
        chk("t2_b1", log_at(1), 8'h45);
        chk("t2_hold_cmd", cnt_val(8'h8A), 3);
        chk("t2_hold_dat", cnt_val(8'h45), 3);
        chk("t2_stp", stp_log.size() > 0 ? int'(stp_log[0]) : -1, 8'h00);
        chk("t2_regdone", n_regdone, 1);
        chk("t2_done", n_done, 0);
        chk("t2_req_low", reg_wr_req, 0);

        // T3: DIR rises in TXCMD before NXT; PID retried after turnaround
        clear_logs(); nxt_delay = 1; nxt_per_byte = 0;
        dir_len = 2; dir_trig_busy = 1;
        push_pkt(8'hC3, 0); push_pkt(8'h11, 1);
        run(20);
        chk("t3_dir_busy", dir_busy, 1);
        chk("t3_b0", log_at(0), 8'h43);
        chk("t3_b1", log_at(1), 8'h11);
        chk("t3_ready", n_ready, 2);
        chk("t3_done", n_done, 1);
        chk("t3_count", cnt_at_end, 2);
        chk("t3_abort", n_abort, 0);
        chk("t3_viol", viol, 0);

        // T4: DIR after two data bytes of a five-byte packet
        clear_logs(); nxt_delay = 1; nxt_per_byte = 0;
        dir_len = 4; dir_trig_pops = 3;
        push_pkt(8'hC3, 0); push_pkt(8'hA1, 0); push_pkt(8'hA2, 0);
        push_pkt(8'hA3, 0); push_pkt(8'hA4, 1);
        run(25);
        chk("t4_abort", n_abort, 1);
        chk("t4_count", cnt_at_end, 3);
        chk("t4_stp", stp_log.size(), 0);
        chk("t4_done", n_done, 0);
        chk("t4_flushed", popped, 5);
        chk("t4_ready", n_ready, 5);
        chk("t4_nbytes", nxt_log.size(), 3);
        chk("t4_viol", viol, 0);

        // T5: underrun -- source runs dry with NXT high
        clear_logs(); nxt_delay = 1; nxt_per_byte = 0;
        push_pkt(8'hC3, 0); push_pkt(8'h11, 0); push_pkt(8'h22, 0);
        run(20);
        chk("t5_stp", stp_log.size() > 0 ? int'(stp_log[0]) : -1, 8'hFF);
        chk("t5_abort", n_abort, 1);
        chk("t5_done", n_done, 0);
        chk("t5_count", cnt_at_end, 3);
        chk("t5_busy_end", busy, 0);

        // T6: reset mid-DATA, then register write and packet requested together
        clear_logs(); nxt_delay = 1; nxt_per_byte = 0;
        push_pkt(8'hC3, 0); push_pkt(8'h11, 0); push_pkt(8'h22, 0);
        push_pkt(8'h33, 1);
        for (int i = 0; i < 20 && popped < 2; i++) tick();
        @(posedge clk_ULPI); #1;
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_oe", DATA_OE, 0);
        chk("t6_rst_data", DATA_O, 0);
        chk("t6_rst_stp", STP, 0);
        chk("t6_rst_ready", tx_ready, 0);
        chk("t6_rst_count", int'(tx_count), 0);
        chk("t6_rst_pulses", {tx_done, tx_abort, reg_wr_done}, 0);
        src_q.delete(); rdy_seen = 0;
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; NXT = 1'b0;
        @(posedge clk_ULPI); #1;
        rst = 1'b0;
        clear_logs();
        reg_addr = 6'h15; reg_wr_data = 8'h99; reg_wr_req = 1'b1;
        push_pkt(8'hC3, 0); push_pkt(8'h11, 1);
        run(30);
        chk("t6_b0", log_at(0), 8'h95);
        chk("t6_b1", log_at(1), 8'h99);
        chk("t6_b2", log_at(2), 8'h43);
        chk("t6_b3", log_at(3), 8'h11);
        chk("t6_regdone", n_regdone, 1);
        chk("t6_done", n_done, 1);
        chk("t6_order", int'(regdone_cyc >= 0 && regdone_cyc < done_cyc), 1);
        chk("t6_gap", gap_meas, 3);
        chk("t6_count", cnt_at_end, 2);
        chk("t6_viol", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
